// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash controller slice.
//   state_e        : byte engine FSM states
//   OP_*           : flash opcodes issued by the command sequencer
//   SPI_BYTE_W     : width of one SPI transfer unit
package spi_flash_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  localparam logic [SPI_BYTE_W-1:0] OP_READ        = 8'h03;
  localparam logic [SPI_BYTE_W-1:0] OP_JEDEC_ID    = 8'h9F;
  localparam logic [SPI_BYTE_W-1:0] OP_RELEASE_PD  = 8'hAB;
  localparam logic [SPI_BYTE_W-1:0] OP_READ_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_CS_HOLD,
    ST_CS_IDLE
  } state_e;

endpackage

// File: rtl/spi_byte_engine.sv
// Byte-level SPI master, mode 0, MSB first. Chip select spans consecutive
// bytes until a byte flagged last completes.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_tx_valid/o_tx_ready        : byte stream handshake
//   i_tx_data, i_tx_last         : byte to send, end-of-transaction flag
//   o_rx_valid, o_rx_data        : one-cycle pulse with the received byte
//   o_busy                       : engine not idle
//   o_spi_cs_n/clk/mosi, i_spi_miso : flash pins
module spi_byte_engine
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned CS_IDLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic [SPI_BYTE_W-1:0] i_tx_data,
  input  logic                  i_tx_last,
  output logic                  o_rx_valid,
  output logic [SPI_BYTE_W-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_spi_cs_n,
  output logic                  o_spi_clk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int unsigned IDLE_W = $clog2(CS_IDLE_CYCLES) + 1;

  state_e                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [2:0]              bit_q;
  logic [IDLE_W-1:0]       idle_q;
  logic [SPI_BYTE_W-1:0]   tx_sr_q;
  logic [SPI_BYTE_W-1:0]   rx_sr_q;
  logic                    last_q;
  logic                    cs_n_q;
  logic                    sclk_q;
  logic                    mosi_q;
  logic                    rx_valid_q;
  logic [SPI_BYTE_W-1:0]   rx_data_q;

  logic div_done;
  assign div_done = (div_q == DIV_W'(CLK_DIV - 1));

  // Engine FSM with registered pin and rx outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      idle_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      last_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (i_tx_valid) begin
            tx_sr_q <= i_tx_data;
            last_q  <= i_tx_last;
            mosi_q  <= i_tx_data[SPI_BYTE_W-1];
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_done) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              // Rising edge: capture MISO.
              rx_sr_q <= {rx_sr_q[SPI_BYTE_W-2:0], i_spi_miso};
            end else begin
              // Falling edge: present the next bit, or close the byte.
              bit_q   <= bit_q + 3'd1;
              tx_sr_q <= {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
              mosi_q  <= tx_sr_q[SPI_BYTE_W-2];
              if (bit_q == 3'(SPI_BYTE_W - 1)) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_sr_q;
                state_q    <= last_q ? ST_CS_HOLD : ST_GAP;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_CS_HOLD: begin
          if (div_done) begin
            div_q   <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            idle_q  <= '0;
            state_q <= ST_CS_IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_CS_IDLE: begin
          if (idle_q == IDLE_W'(CS_IDLE_CYCLES - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready and busy are plain decodes of the state register.
  assign o_tx_ready = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign o_busy     = (state_q != ST_IDLE);

  assign o_rx_valid = rx_valid_q;
  assign o_rx_data  = rx_data_q;
  assign o_spi_cs_n = cs_n_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: dut0 (CLK_DIV=2) and dut1 (CLK_DIV=1).
module tb_spi_byte_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0 signals
  logic       tx_valid0 = 1'b0, tx_last0 = 1'b0;
  logic [7:0] tx_data0 = 8'h00;
  logic       tx_ready0, rx_valid0, busy0, cs_n0, sclk0, mosi0, miso0;
  logic [7:0] rx_data0;

  // dut1 signals
  logic       tx_valid1 = 1'b0, tx_last1 = 1'b0;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_ready1, rx_valid1, busy1, cs_n1, sclk1, mosi1, miso1;
  logic [7:0] rx_data1;

  spi_byte_engine #(.CLK_DIV(2), .CS_IDLE_CYCLES(4)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_tx_valid(tx_valid0), .o_tx_ready(tx_ready0),
    .i_tx_data(tx_data0), .i_tx_last(tx_last0),
    .o_rx_valid(rx_valid0), .o_rx_data(rx_data0), .o_busy(busy0),
    .o_spi_cs_n(cs_n0), .o_spi_clk(sclk0), .o_spi_mosi(mosi0),
    .i_spi_miso(miso0)
  );

  spi_byte_engine #(.CLK_DIV(1), .CS_IDLE_CYCLES(4)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_tx_valid(tx_valid1), .o_tx_ready(tx_ready1),
    .i_tx_data(tx_data1), .i_tx_last(tx_last1),
    .o_rx_valid(rx_valid1), .o_rx_data(rx_data1), .o_busy(busy1),
    .o_spi_cs_n(cs_n1), .o_spi_clk(sclk1), .o_spi_mosi(mosi1),
    .i_spi_miso(miso1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Edge / pulse monitors
  int rise_cnt0 = 0, rise_cnt1 = 0;
  int rx_cnt0 = 0, rx_cnt1 = 0;
  int cs_hi_cnt0 = 0;
  logic [7:0] rx_log0 [16];

  always @(posedge sclk0) rise_cnt0 <= rise_cnt0 + 1;
  always @(posedge sclk1) rise_cnt1 <= rise_cnt1 + 1;
  always @(posedge clk) begin
    if (rx_valid0) begin
      rx_log0[4'(rx_cnt0)] <= rx_data0;
      rx_cnt0 <= rx_cnt0 + 1;
    end
    if (rx_valid1) rx_cnt1 <= rx_cnt1 + 1;
    if (cs_n0) cs_hi_cnt0 <= cs_hi_cnt0 + 1;
  end

  // MISO stubs: flash model presents bit k of the transaction before rising edge k.
  logic       loop0 = 1'b1;
  int         rise_base0 = 0, rise_base1 = 0;
  int         k0, k1;
  logic [7:0] stub0 [4];
  logic [7:0] sb0, stub1;
  initial begin
    stub0[0] = 8'hFF; stub0[1] = 8'hEF; stub0[2] = 8'h40; stub0[3] = 8'h16;
    stub1 = 8'h6B;
  end

  always_comb begin
    k0  = rise_cnt0 - rise_base0;
    sb0 = stub0[2'((k0 / 8) % 4)];
    if (loop0) miso0 = mosi0;
    else if (k0 >= 0 && k0 < 32) miso0 = sb0[3'(7 - (k0 % 8))];
    else miso0 = 1'b0;
  end

  always_comb begin
    k1 = rise_cnt1 - rise_base1;
    if (k1 >= 0 && k1 < 8) miso1 = stub1[3'(7 - k1)];
    else miso1 = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte to dut0; returns in cycle T+1.
  task automatic send0(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    while (!tx_ready0 && n < 200) begin tick(); n++; end
    chk("send_ready_timeout", 32'(tx_ready0), 1);
    tx_valid0 = 1'b1; tx_data0 = d; tx_last0 = l;
    tick();
    tx_valid0 = 1'b0; tx_data0 = 8'($urandom); tx_last0 = 1'b0;
  endtask

  task automatic wait_rx0(input int target);
    int n;
    n = 0;
    while (rx_cnt0 < target && n < 200) begin tick(); n++; end
    chk("rx_timeout", 32'(rx_cnt0 >= target), 1);
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (busy0 && n < 200) begin tick(); n++; end
    chk("idle_timeout", 32'(busy0), 0);
  endtask

  initial begin
    int base, cs_base, rdy_hi;

    // Reset state
    repeat (3) tick();
    chk("rst_cs_n", 32'(cs_n0), 1);
    chk("rst_sclk", 32'(sclk0), 0);
    chk("rst_mosi", 32'(mosi0), 0);
    chk("rst_rx_valid", 32'(rx_valid0), 0);
    chk("rst_rx_data", 32'(rx_data0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ready", 32'(tx_ready0), 1);
    rst = 1'b0;
    tick();

    // 1: loopback single byte 0xA5, exact timing
    base = rise_cnt0;
    send0(8'hA5, 1'b1);                         // now T+1
    chk("t1_cs_low", 32'(cs_n0), 0);
    chk("t1_mosi_b7", 32'(mosi0), 1);
    chk("t1_busy", 32'(busy0), 1);
    repeat (31) tick();                         // T+32
    chk("t1_rx_early", 32'(rx_valid0), 0);
    tick();                                     // T+33
    chk("t1_rx_valid", 32'(rx_valid0), 1);
    chk("t1_rx_data", 32'(rx_data0), 32'hA5);
    chk("t1_cs_hold", 32'(cs_n0), 0);
    tick();                                     // T+34
    chk("t1_rx_pulse", 32'(rx_valid0), 0);
    chk("t1_cs_still_low", 32'(cs_n0), 0);
    tick();                                     // T+35
    chk("t1_cs_high", 32'(cs_n0), 1);
    chk("t1_mosi_idle", 32'(mosi0), 0);
    repeat (3) tick();                          // T+38
    chk("t1_ready_idle_gap", 32'(tx_ready0), 0);
    tick();                                     // T+39
    chk("t1_ready_back", 32'(tx_ready0), 1);
    chk("t1_rises", 32'(rise_cnt0 - base), 8);
    chk("t1_rx_hold", 32'(rx_data0), 32'hA5);

    // 2: JEDEC ID read against flash stub
    loop0 = 1'b0;
    rise_base0 = rise_cnt0;
    base = rx_cnt0;
    send0(8'h9F, 1'b0);
    cs_base = cs_hi_cnt0;
    send0(8'h00, 1'b0);
    send0(8'h00, 1'b0);
    send0(8'h00, 1'b1);
    wait_rx0(base + 4);
    chk("t2_rx1", 32'(rx_log0[4'(base + 1)]), 32'hEF);
    chk("t2_rx2", 32'(rx_log0[4'(base + 2)]), 32'h40);
    chk("t2_rx3", 32'(rx_log0[4'(base + 3)]), 32'h16);
    chk("t2_cs_continuous", 32'(cs_hi_cnt0 - cs_base), 0);
    chk("t2_rises", 32'(rise_cnt0 - rise_base0), 32);
    wait_idle0();
    loop0 = 1'b1;

    // 3: GAP stall
    base = rx_cnt0;
    send0(8'h03, 1'b0);
    wait_rx0(base + 1);
    chk("t3_rx_03", 32'(rx_data0), 32'h03);
    cs_base = cs_hi_cnt0;
    rise_base0 = rise_cnt0;
    repeat (50) tick();
    chk("t3_gap_cs", 32'(cs_hi_cnt0 - cs_base), 0);
    chk("t3_gap_rises", 32'(rise_cnt0 - rise_base0), 0);
    chk("t3_gap_sclk", 32'(sclk0), 0);
    chk("t3_gap_busy", 32'(busy0), 1);
    chk("t3_gap_ready", 32'(tx_ready0), 1);
    send0(8'h12, 1'b1);
    wait_rx0(base + 2);
    chk("t3_rx_12", 32'(rx_data0), 32'h12);
    wait_idle0();

    // 4: reset at the 4th rising edge
    rise_base0 = rise_cnt0;
    base = rx_cnt0;
    send0(8'h5A, 1'b1);
    begin
      int n;
      n = 0;
      while ((rise_cnt0 - rise_base0) < 4 && n < 100) begin tick(); n++; end
    end
    chk("t4_reach_rise4", 32'(rise_cnt0 - rise_base0), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_cs_n", 32'(cs_n0), 1);
    chk("t4_sclk", 32'(sclk0), 0);
    chk("t4_mosi", 32'(mosi0), 0);
    chk("t4_rx_data", 32'(rx_data0), 0);
    chk("t4_busy", 32'(busy0), 0);
    repeat (40) tick();
    chk("t4_no_rx", 32'(rx_cnt0 - base), 0);
    // handshake coinciding with reset is dropped
    rst = 1'b1; tx_valid0 = 1'b1; tx_data0 = 8'hC3; tx_last0 = 1'b1;
    tick();
    rst = 1'b0; tx_valid0 = 1'b0;
    chk("t4_rst_hs_busy", 32'(busy0), 0);
    chk("t4_rst_hs_cs", 32'(cs_n0), 1);
    base = rx_cnt0;
    send0(8'h3C, 1'b1);
    wait_rx0(base + 1);
    chk("t4_rx_3C", 32'(rx_data0), 32'h3C);
    wait_idle0();

    // 5: valid held high with changing data through SHIFT/CS_HOLD/CS_IDLE
    base = rx_cnt0;
    send0(8'hA5, 1'b1);                         // T+1
    rdy_hi = 0;
    tx_valid0 = 1'b1;
    for (int i = 0; i < 37; i++) begin
      tx_data0 = 8'($urandom);
      tx_last0 = 1'($urandom);
      tick();                                   // T+2 .. T+38
      if (tx_ready0) rdy_hi++;
    end
    tx_valid0 = 1'b0;
    chk("t5_ready_low", 32'(rdy_hi), 0);
    chk("t5_one_rx", 32'(rx_cnt0 - base), 1);
    chk("t5_rx_data", 32'(rx_data0), 32'hA5);
    tick();                                     // T+39
    chk("t5_idle", 32'(busy0), 0);
    chk("t5_ready", 32'(tx_ready1 & tx_ready0), 1);

    // 6: CLK_DIV=1, stub returns 0x6B
    rise_base1 = rise_cnt1;
    base = rx_cnt1;
    tx_valid1 = 1'b1; tx_data1 = 8'h81; tx_last1 = 1'b1;
    tick();                                     // T+1
    tx_valid1 = 1'b0; tx_data1 = 8'h00;
    chk("t6_cs_low", 32'(cs_n1), 0);
    chk("t6_mosi_b7", 32'(mosi1), 1);
    repeat (15) tick();                         // T+16
    chk("t6_rx_early", 32'(rx_valid1), 0);
    tick();                                     // T+17
    chk("t6_rx_valid", 32'(rx_valid1), 1);
    chk("t6_rx_data", 32'(rx_data1), 32'h6B);
    chk("t6_cs_hold", 32'(cs_n1), 0);
    tick();                                     // T+18
    chk("t6_cs_high", 32'(cs_n1), 1);
    chk("t6_rises", 32'(rise_cnt1 - rise_base1), 8);
    chk("t6_one_rx", 32'(rx_cnt1 - base), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
